stream_demux_1ton: RTL and testbench
====================================

Name: stream_demux_1toN

Overview:
- Registered, handshaked 1-to-NCH demultiplexer. It is the parametrised successor of the team's combinational 1-to-4 demux.
- Routes WIDTH-bit beats from one valid/ready source to one of NCH valid/ready sinks.
- Destination comes from an explicit select or from an internal round-robin pointer.
- Holds each beat in a single output register stage, so the sink can stall without losing it.
- Sits between a single producer and multiple downstream consumers in the data-routing library.

Parameters:
- WIDTH, 8, data width per channel.
- NCH, 4, number of output channels (2..16).
- SELW, 4, select width; must satisfy 2**SELW >= NCH.
- CNTW, 8, width of the dropped-beat counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- rr_en  in  1  1 = round-robin routing (sel ignored); 0 = select routing.
- i_data  in  WIDTH  input beat.
- i_sel  in  SELW  destination channel, sampled with the beat.
- i_valid  in  1  input beat valid.
- i_ready  out  1  block accepts the beat this cycle.
- o_data  out  NCH*WIDTH  flattened outputs; channel k occupies bits [k*WIDTH +: WIDTH].
- o_valid  out  NCH  per-channel valid, one-hot or zero.
- o_ready  in  NCH  per-channel sink ready.
- drop_pulse  out  1  one-cycle pulse when a beat with out-of-range sel is discarded.
- drop_cnt  out  CNTW  saturating count of discarded beats.
- rr_ptr  out  SELW  current round-robin pointer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - o_data, o_valid, drop_pulse, drop_cnt and rr_ptr are all 0.
  - Internal holding register is empty.
  - i_ready is 0 while rst_n is low; after release it follows the equation below.
- Storage: one holding register containing {data, ch, full}.
  - o_valid[k] = full && (ch == k).
  - o_data channel k = data when o_valid[k], else 0. Non-selected channels always drive zero.
- Output-side handshake:
  - out_fire = full && o_ready[ch].
  - i_ready = !full || o_ready[ch], which is a combinational path from o_ready.
- Input-side handshake:
  - in_fire = i_valid && i_ready.
  - Latency: a beat accepted at edge N is visible on o_valid/o_data after edge N.
  - Throughput is 1 beat/cycle when the destination sink keeps o_ready high.
- Destination (dest):
  - dest = rr_ptr when rr_en = 1.
  - dest = i_sel when rr_en = 0.
- Per-edge update:
  - in_fire and dest < NCH: register loads {i_data, dest, 1}. This holds even when out_fire occurs on the same edge (simultaneous drain and refill).
  - in_fire and dest >= NCH (select mode only):
    - Beat is consumed, not stored.
    - drop_pulse = 1 for one cycle.
    - drop_cnt increments, saturating at 2**CNTW-1.
    - If out_fire occurs on the same edge, full clears.
  - No in_fire and out_fire: full clears and o_valid returns to 0.
  - While full and not out_fire: data/ch are stable, and o_valid stays asserted for the stalled sink.
- Round-robin pointer:
  - Advances only on an in_fire that stores a beat while rr_en = 1.
  - Wraps from NCH-1 to 0.
  - Holds its value when rr_en = 0.
  - Out-of-range sel drops never move the pointer.
- Mode change: rr_en may toggle on any cycle. It affects only beats accepted on or after that edge; a held beat keeps its channel.
- Stall behaviour: a stalled sink k blocks all input, including beats destined for other channels. There is no per-channel buffering and no reordering.
- Reset mid-operation: a held beat is discarded, o_valid drops to 0 immediately (asynchronous), and counters and pointer clear.
- Implementation: i_data/i_sel must not reach the outputs combinationally; outputs are driven from the holding register.

Test Plan:
- Select mode, all o_ready = 1:
  - Stimulus: beats 0x11, 0x22, 0x33, 0x44 on back-to-back cycles with sel = 0, 1, 2, 3.
  - Required response: each beat appears one cycle later on o_valid = 0001, 0010, 0100, 1000 with matching data. Other lanes read 0. i_ready stays 1.
- Backpressure:
  - Stimulus: o_ready[2] = 0; send 0xA5 with sel = 2, then 0x5A with sel = 1.
  - Required response: o_valid = 0100 and 0xA5 hold steady, and i_ready = 0, for 5 cycles. Raising o_ready[2] drains 0xA5 and accepts 0x5A on the same edge; the next cycle shows o_valid = 0010 with 0x5A.
- Round-robin:
  - Stimulus: rr_en = 1, i_sel = 3 (ignored), 6 consecutive beats.
  - Required response: channels 0, 1, 2, 3, 0, 1; rr_ptr ends at 2.
  - Follow-up: drop rr_en for 2 beats with sel = 3; rr_ptr stays 2.
- Invalid select:
  - Setup: NCH = 4, SELW = 4, CNTW = 2 (out-of-range sel values are representable).
  - Stimulus: sel = 9 for 4 beats.
  - Required response: no o_valid, one drop_pulse per beat, drop_cnt reads 1, 2, 3, 3 (saturates).
- Asynchronous reset:
  - Stimulus: while a beat is held on channel 1 with o_ready = 0 and rr_ptr = 3, assert rst_n low mid-cycle.
  - Required response: o_valid = 0, o_data = 0, rr_ptr = 0 and drop_cnt = 0 before the next clock edge. After release, the first beat routes per sel.

Source files
------------

// File: rtl/stream_demux_1ton.sv
// Registered, handshaked 1-to-NCH stream demultiplexer.
// A single holding register {data, ch, full} feeds the selected sink.
// The destination comes from i_sel or from an internal round-robin pointer.
// Beats with an out-of-range select are consumed and counted, not stored.
module stream_demux_1ton #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rr_en,
  input  logic [WIDTH-1:0]     i_data,
  input  logic [SELW-1:0]      i_sel,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic [NCH*WIDTH-1:0] o_data,
  output logic [NCH-1:0]       o_valid,
  input  logic [NCH-1:0]       o_ready,
  output logic                 drop_pulse,
  output logic [CNTW-1:0]      drop_cnt,
  output logic [SELW-1:0]      rr_ptr
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             full_q, full_d;
  logic             drop_q, drop_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             ready_sel;
  logic             out_fire;
  logic             in_fire;
  logic [SELW-1:0]  dest;
  logic             dest_ok;

  // Handshake terms: ready of the held channel, fire conditions, destination
  always_comb begin
    ready_sel = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_q == SELW'(k)) ready_sel = o_ready[k];
    end
    out_fire = full_q && ready_sel;
    // Held low during reset so no beat is taken while the register is cleared
    i_ready  = rst_n && (!full_q || ready_sel);
    in_fire  = i_valid && i_ready;
    dest     = rr_en ? ptr_q : i_sel;
    // Widened by one bit so NCH == 2**SELW still compares correctly
    dest_ok  = ({1'b0, dest} < (SELW+1)'(NCH));
  end

  // Next-state: drain, refill (possibly on the same edge), drop accounting
  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    full_d = full_q;
    drop_d = 1'b0;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    if (out_fire) full_d = 1'b0;
    if (in_fire) begin
      if (dest_ok) begin
        data_d = i_data;
        ch_d   = dest;
        full_d = 1'b1;
        if (rr_en) begin
          ptr_d = (ptr_q == SELW'(NCH-1)) ? '0 : ptr_q + SELW'(1);
        end
      end else begin
        drop_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
      full_q <= 1'b0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      full_q <= full_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
    end
  end

  // Output lanes: only the held channel carries data, all others read zero
  always_comb begin
    o_data  = '0;
    o_valid = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (full_q && (ch_q == SELW'(k))) begin
        o_valid[k]                = 1'b1;
        o_data[k*WIDTH +: WIDTH]  = data_q;
      end
    end
  end

  assign drop_pulse = drop_q;
  assign drop_cnt   = cnt_q;
  assign rr_ptr     = ptr_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for stream_demux_1ton (NCH=4, WIDTH=8, SELW=4, CNTW=2).
module tb_stream_demux_1ton;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 4;
  localparam int unsigned SELW  = 4;
  localparam int unsigned CNTW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 rr_en;
  logic [WIDTH-1:0]     i_data;
  logic [SELW-1:0]      i_sel;
  logic                 i_valid;
  logic                 i_ready;
  logic [NCH*WIDTH-1:0] o_data;
  logic [NCH-1:0]       o_valid;
  logic [NCH-1:0]       o_ready;
  logic                 drop_pulse;
  logic [CNTW-1:0]      drop_cnt;
  logic [SELW-1:0]      rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  stream_demux_1ton #(
    .WIDTH(WIDTH),
    .NCH  (NCH),
    .SELW (SELW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_en     (rr_en),
    .i_data    (i_data),
    .i_sel     (i_sel),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .drop_pulse(drop_pulse),
    .drop_cnt  (drop_cnt),
    .rr_ptr    (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rr_en = 1'b0; i_data = '0; i_sel = '0; i_valid = 1'b0; o_ready = '1;
    #3;
    n_checks++; if (o_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", o_valid); end
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", o_data); end
    n_checks++; if (drop_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", drop_cnt); end
    n_checks++; if (rr_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", rr_ptr); end
    n_checks++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", drop_pulse); end
    n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_iready: got %b expected 0", i_ready); end
    step(); step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_iready: got %b expected 1", i_ready); end
  endtask

  task automatic test_select();
    logic [7:0]  beats [4];
    logic [31:0] exp_d;
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
    step();
    rr_en = 1'b0; o_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      i_data = beats[i]; i_sel = 4'(i); i_valid = 1'b1;
      #1;
      n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL sel_iready[%0d]: got %b expected 1", i, i_ready); end
      step();
      exp_d = 32'(beats[i]) << (8*i);
      n_checks++; if (o_valid !== 4'(1 << i)) begin n_fail++; $display("FAIL sel_valid[%0d]: got %b expected %b", i, o_valid, 4'(1 << i)); end
      n_checks++; if (o_data !== exp_d) begin n_fail++; $display("FAIL sel_data[%0d]: got %h expected %h", i, o_data, exp_d); end
    end
    i_valid = 1'b0;
    step();
    n_checks++; if (o_valid !== 4'b0000) begin n_fail++; $display("FAIL sel_idle_valid: got %b expected 0000", o_valid); end
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL sel_idle_data: got %h expected 0", o_data); end
  endtask

  task automatic test_backpressure();
    o_ready = 4'b1011;
    i_data = 8'hA5; i_sel = 4'd2; i_valid = 1'b1;
    step();
    i_data = 8'h5A; i_sel = 4'd1; i_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (o_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 0100", c, o_valid); end
      n_checks++; if (o_data !== 32'h00A50000) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected 00a50000", c, o_data); end
      n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL bp_iready[%0d]: got %b expected 0", c, i_ready); end
      if (c < 5) step();
    end
    o_ready = 4'hF;
    #1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_iready: got %b expected 1", i_ready); end
    step();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_next_valid: got %b expected 0010", o_valid); end
    n_checks++; if (o_data !== 32'h00005A00) begin n_fail++; $display("FAIL bp_next_data: got %h expected 00005a00", o_data); end
    step();
    n_checks++; if (o_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_drain_valid: got %b expected 0000", o_valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d;
    rr_en = 1'b1; i_sel = 4'd3; o_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      i_data = 8'(8'h60 + i); i_valid = 1'b1;
      step();
      exp_d = 32'(8'h60 + i) << (8*(i % 4));
      n_checks++; if (o_valid !== 4'(1 << (i % 4))) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b expected %b", i, o_valid, 4'(1 << (i % 4))); end
      n_checks++; if (o_data !== exp_d) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, o_data, exp_d); end
      n_checks++; if (rr_ptr !== 4'((i + 1) % 4)) begin n_fail++; $display("FAIL rr_ptr[%0d]: got %0d expected %0d", i, rr_ptr, (i + 1) % 4); end
    end
    rr_en = 1'b0; i_sel = 4'd3;
    for (int i = 0; i < 2; i++) begin
      i_data = 8'(8'h70 + i);
      step();
      n_checks++; if (o_valid !== 4'b1000) begin n_fail++; $display("FAIL rr_off_valid[%0d]: got %b expected 1000", i, o_valid); end
      n_checks++; if (rr_ptr !== 4'd2) begin n_fail++; $display("FAIL rr_off_ptr[%0d]: got %0d expected 2", i, rr_ptr); end
    end
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_invalid_sel();
    logic [1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
    rr_en = 1'b0; i_sel = 4'd9; o_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      i_data = 8'(8'h90 + i); i_valid = 1'b1;
      #1;
      n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL inv_iready[%0d]: got %b expected 1", i, i_ready); end
      step();
      n_checks++; if (o_valid !== 4'b0000) begin n_fail++; $display("FAIL inv_valid[%0d]: got %b expected 0000", i, o_valid); end
      n_checks++; if (drop_pulse !== 1'b1) begin n_fail++; $display("FAIL inv_pulse[%0d]: got %b expected 1", i, drop_pulse); end
      n_checks++; if (drop_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL inv_cnt[%0d]: got %0d expected %0d", i, drop_cnt, exp_cnt[i]); end
    end
    i_valid = 1'b0;
    step();
    n_checks++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL inv_pulse_end: got %b expected 0", drop_pulse); end
    n_checks++; if (drop_cnt !== 2'd3) begin n_fail++; $display("FAIL inv_cnt_end: got %0d expected 3", drop_cnt); end
  endtask

  task automatic test_async_reset();
    // ptr 2 -> 3 via an RR beat on ch2, then park a select beat on stalled ch1
    o_ready = 4'b1101;
    rr_en = 1'b1; i_data = 8'h77; i_valid = 1'b1;
    step();
    rr_en = 1'b0; i_sel = 4'd1; i_data = 8'h99;
    step();
    i_valid = 1'b0;
    step();
    n_checks++; if (o_valid !== 4'b0010) begin n_fail++; $display("FAIL ar_pre_valid: got %b expected 0010", o_valid); end
    n_checks++; if (rr_ptr !== 4'd3) begin n_fail++; $display("FAIL ar_pre_ptr: got %0d expected 3", rr_ptr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_valid !== 4'b0000) begin n_fail++; $display("FAIL ar_valid: got %b expected 0000", o_valid); end
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL ar_data: got %h expected 0", o_data); end
    n_checks++; if (rr_ptr !== 4'd0) begin n_fail++; $display("FAIL ar_ptr: got %0d expected 0", rr_ptr); end
    n_checks++; if (drop_cnt !== 2'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d expected 0", drop_cnt); end
    step();
    rst_n = 1'b1;
    o_ready = 4'hF; i_sel = 4'd3; i_data = 8'hC3; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 4'b1000) begin n_fail++; $display("FAIL ar_after_valid: got %b expected 1000", o_valid); end
    n_checks++; if (o_data !== 32'hC3000000) begin n_fail++; $display("FAIL ar_after_data: got %h expected c3000000", o_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_round_robin();
    test_invalid_sel();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
